// File: rtl/seg7_chase_pkg.sv
// seg7_chase_pkg
//   Shared definitions for the seven-segment chase ring:
//   - segment bit indices inside one display byte (a..g, dp)
//   - chase mode enumeration (LOOP, BOUNCE)
//   - ring_len(): number of positions around the outer edge of the displays
package seg7_chase_pkg;

  localparam int SEG_A    = 0;
  localparam int SEG_B    = 1;
  localparam int SEG_C    = 2;
  localparam int SEG_D    = 3;
  localparam int SEG_E    = 4;
  localparam int SEG_F    = 5;
  localparam int SEG_G    = 6;
  localparam int SEG_DP   = 7;
  localparam int SEG_BITS = 8;

  typedef enum logic {
    LOOP   = 1'b0,
    BOUNCE = 1'b1
  } mode_t;

  // Top row (N segments a), right edge (b, c), bottom row (N segments d),
  // left edge (e, f).
  function automatic int ring_len(input int num_displays);
    return 2 * num_displays + 4;
  endfunction

endpackage

// File: rtl/seg7_chase_decode.sv
// seg7_chase_decode
//   Maps one ring position to a one-hot mask over all display segments.
//   Ports:
//     pos  - ring position, 0..L-1
//     mask - NUM_DISPLAYS x 8 bits, display d in mask[d*8 +: 8], one bit set
//   Ring order runs clockwise: across the top (a), down the right-hand
//   display (b, c), back along the bottom (d), up the left-hand display (e, f).
module seg7_chase_decode
  import seg7_chase_pkg::*;
#(
  parameter int NUM_DISPLAYS = 6,
  parameter int POS_W        = 4
) (
  input  logic [POS_W-1:0]                 pos,
  output logic [NUM_DISPLAYS*SEG_BITS-1:0] mask
);

  for (genvar gi = 0; gi < NUM_DISPLAYS; gi++) begin : g_disp
    localparam int BASE = gi * SEG_BITS;

    assign mask[BASE+SEG_A] = (pos == POS_W'(gi));
    // Bottom row is traversed right to left.
    assign mask[BASE+SEG_D] = (pos == POS_W'(2 * NUM_DISPLAYS + 1 - gi));
    assign mask[BASE+SEG_G]  = 1'b0;
    assign mask[BASE+SEG_DP] = 1'b0;

    if (gi == NUM_DISPLAYS - 1) begin : g_right
      assign mask[BASE+SEG_B] = (pos == POS_W'(NUM_DISPLAYS));
      assign mask[BASE+SEG_C] = (pos == POS_W'(NUM_DISPLAYS + 1));
    end else begin : g_not_right
      assign mask[BASE+SEG_B] = 1'b0;
      assign mask[BASE+SEG_C] = 1'b0;
    end

    if (gi == 0) begin : g_left
      assign mask[BASE+SEG_E] = (pos == POS_W'(2 * NUM_DISPLAYS + 2));
      assign mask[BASE+SEG_F] = (pos == POS_W'(2 * NUM_DISPLAYS + 3));
    end else begin : g_not_left
      assign mask[BASE+SEG_E] = 1'b0;
      assign mask[BASE+SEG_F] = 1'b0;
    end
  end

endmodule

// File: rtl/seg7_chase.sv
// seg7_chase
//   Lights a moving chain of segments around the outer edge of a row of
//   seven-segment displays, in LOOP (wrap-around) or BOUNCE (ping-pong) mode.
//   Ports:
//     clk_i    - clock, all state on rising edge
//     rst_i    - synchronous active-high reset
//     en_i     - step enable; low freezes tick counter and position
//     dir_i    - LOOP direction: 0 = clockwise (+1), 1 = counter-clockwise
//     mode_i   - 0 = LOOP, 1 = BOUNCE
//     period_i - cycles between steps minus one
//     step_o   - one-cycle pulse together with each new position
//     wrap_o   - one-cycle pulse on LOOP wrap or BOUNCE reversal
//     pos_o    - current head position
//     dir_o    - current direction register
//     seg7_o   - NUM_DISPLAYS x 8 active-high segments (bit0=a .. bit7=dp)
module seg7_chase
  import seg7_chase_pkg::*;
#(
  parameter int NUM_DISPLAYS = 6,
  parameter int PERIOD_W     = 24,
  parameter int TAIL         = 1,
  localparam int L           = ring_len(NUM_DISPLAYS),
  localparam int POS_W       = $clog2(L)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic                             dir_i,
  input  logic                             mode_i,
  input  logic [PERIOD_W-1:0]              period_i,
  output logic                             step_o,
  output logic                             wrap_o,
  output logic [POS_W-1:0]                 pos_o,
  output logic                             dir_o,
  output logic [NUM_DISPLAYS*SEG_BITS-1:0] seg7_o
);

  logic [PERIOD_W-1:0] tick_reg, tick_next;
  logic [POS_W-1:0]    pos_reg, pos_next;
  logic                dir_reg, dir_next;
  logic                step_reg, step_next;
  logic                wrap_reg, wrap_next;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(L - 1);

  always_comb begin
    tick_next = tick_reg;
    pos_next  = pos_reg;
    dir_next  = dir_reg;
    step_next = 1'b0;
    wrap_next = 1'b0;
    if (en_i) begin
      // ">=" rather than "==" so that shrinking period_i below the running
      // count still produces a step on the next enabled edge.
      if (tick_reg >= period_i) begin
        tick_next = '0;
        step_next = 1'b1;
        if (mode_t'(mode_i) == LOOP) begin
          dir_next = dir_i;
          if (!dir_i) begin
            if (pos_reg == POS_LAST) begin
              pos_next  = '0;
              wrap_next = 1'b1;
            end else begin
              pos_next = pos_reg + POS_W'(1);
            end
          end else begin
            if (pos_reg == '0) begin
              pos_next  = POS_LAST;
              wrap_next = 1'b1;
            end else begin
              pos_next = pos_reg - POS_W'(1);
            end
          end
        end else begin
          // Reversal is decided from the current direction register, so
          // entering BOUNCE at an end while heading outward turns back
          // immediately instead of leaving the ring.
          if (!dir_reg) begin
            if (pos_reg == POS_LAST) begin
              pos_next  = POS_W'(L - 2);
              dir_next  = 1'b1;
              wrap_next = 1'b1;
            end else begin
              pos_next = pos_reg + POS_W'(1);
            end
          end else begin
            if (pos_reg == '0) begin
              pos_next  = POS_W'(1);
              dir_next  = 1'b0;
              wrap_next = 1'b1;
            end else begin
              pos_next = pos_reg - POS_W'(1);
            end
          end
        end
      end else begin
        tick_next = tick_reg + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_reg <= '0;
      pos_reg  <= '0;
      dir_reg  <= 1'b0;
      step_reg <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      tick_reg <= tick_next;
      pos_reg  <= pos_next;
      dir_reg  <= dir_next;
      step_reg <= step_next;
      wrap_reg <= wrap_next;
    end
  end

  assign step_o = step_reg;
  assign wrap_o = wrap_reg;
  assign pos_o  = pos_reg;
  assign dir_o  = dir_reg;

  // Tail segment gi sits gi positions behind the head, i.e. against the
  // direction of travel, modulo the ring length.
  logic [NUM_DISPLAYS*SEG_BITS-1:0] tail_mask [TAIL];

  for (genvar gi = 0; gi < TAIL; gi++) begin : g_tail
    logic [POS_W:0]   tail_sum;
    logic [POS_W-1:0] tail_pos;

    always_comb begin
      if (dir_reg) begin
        tail_sum = {1'b0, pos_reg} + (POS_W+1)'(gi);
      end else begin
        tail_sum = {1'b0, pos_reg} + (POS_W+1)'(L - gi);
      end
      if (tail_sum >= (POS_W+1)'(L)) begin
        tail_pos = POS_W'(tail_sum - (POS_W+1)'(L));
      end else begin
        tail_pos = POS_W'(tail_sum);
      end
    end

    seg7_chase_decode #(
      .NUM_DISPLAYS(NUM_DISPLAYS),
      .POS_W       (POS_W)
    ) u_decode (
      .pos (tail_pos),
      .mask(tail_mask[gi])
    );
  end

  always_comb begin
    seg7_o = '0;
    for (int k = 0; k < TAIL; k++) begin
      seg7_o = seg7_o | tail_mask[k];
    end
  end

endmodule

// File: tb/tb_seg7_chase.sv
// tb_seg7_chase
//   Drives a TAIL=1 and a TAIL=3 instance from the same stimulus. Each cycle
//   a behavioural ring model computes the expected outputs, pushes them on a
//   queue, and after the clock edge they are popped and compared.
module tb_seg7_chase;

  localparam int N  = 6;
  localparam int RL = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, en_i, dir_i, mode_i;
  logic [23:0] period_i;

  logic        step_o, wrap_o, dir_o;
  logic [3:0]  pos_o;
  logic [47:0] seg7_o;

  logic        step3, wrap3, dir3;
  logic [3:0]  pos3;
  logic [47:0] seg3;

  seg7_chase #(.NUM_DISPLAYS(N), .PERIOD_W(24), .TAIL(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .dir_i(dir_i), .mode_i(mode_i),
    .period_i(period_i), .step_o(step_o), .wrap_o(wrap_o), .pos_o(pos_o),
    .dir_o(dir_o), .seg7_o(seg7_o)
  );

  seg7_chase #(.NUM_DISPLAYS(N), .PERIOD_W(24), .TAIL(3)) dut3 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .dir_i(dir_i), .mode_i(mode_i),
    .period_i(period_i), .step_o(step3), .wrap_o(wrap3), .pos_o(pos3),
    .dir_o(dir3), .seg7_o(seg3)
  );

  typedef struct {
    logic        step;
    logic        wrap;
    logic [3:0]  pos;
    logic        dir;
    logic [47:0] seg;
    logic [47:0] seg_t3;
  } exp_t;

  exp_t exp_q [$];

  int n_tests  = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int wrap_cnt = 0;
  int cyc      = 0;

  // Reference state
  int m_pos  = 0;
  int m_dir  = 0;
  int m_tick = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Global bit index of the segment at ring position p (display*8 + segment).
  function automatic int ring_bit(input int p);
    if (p < 6)        return p * 8;          // top row, seg a
    else if (p == 6)  return 5 * 8 + 1;      // right display, seg b
    else if (p == 7)  return 5 * 8 + 2;      // right display, seg c
    else if (p < 14)  return (13 - p) * 8 + 3; // bottom row, seg d
    else if (p == 14) return 4;              // left display, seg e
    else              return 5;              // left display, seg f
  endfunction

  function automatic logic [47:0] seg_model(input int pos, input int dir, input int tail);
    logic [47:0] v;
    int p;
    v = '0;
    for (int k = 0; k < tail; k++) begin
      p = dir ? (pos + k) % RL : (pos - k + RL) % RL;
      v[ring_bit(p)] = 1'b1;
    end
    return v;
  endfunction

  task automatic drive(input logic r, input logic en, input logic d,
                       input logic mode_v, input int per);
    exp_t e;
    int   st, wr;
    rst_i    = r;
    en_i     = en;
    dir_i    = d;
    mode_i   = mode_v;
    period_i = 24'(per);
    st = 0;
    wr = 0;
    if (r) begin
      m_pos = 0; m_dir = 0; m_tick = 0;
    end else if (en) begin
      if (m_tick >= per) begin
        m_tick = 0;
        st = 1;
        if (!mode_v) begin
          wr    = d ? (m_pos == 0) : (m_pos == RL - 1);
          m_dir = d;
          m_pos = (m_pos + (d ? RL - 1 : 1)) % RL;
        end else if (m_dir == 0 && m_pos == RL - 1) begin
          m_dir = 1; m_pos = RL - 2; wr = 1;
        end else if (m_dir == 1 && m_pos == 0) begin
          m_dir = 0; m_pos = 1; wr = 1;
        end else begin
          m_pos = m_dir ? m_pos - 1 : m_pos + 1;
        end
      end else begin
        m_tick++;
      end
    end
    e.step   = st[0];
    e.wrap   = wr[0];
    e.pos    = 4'(m_pos);
    e.dir    = m_dir[0];
    e.seg    = seg_model(m_pos, m_dir, 1);
    e.seg_t3 = seg_model(m_pos, m_dir, 3);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check_val("step", 64'(step_o), 64'(e.step));
    check_val("wrap", 64'(wrap_o), 64'(e.wrap));
    check_val("pos",  64'(pos_o),  64'(e.pos));
    check_val("dir",  64'(dir_o),  64'(e.dir));
    check_val("seg",  64'(seg7_o), 64'(e.seg));
    check_val("seg_tail3", 64'(seg3), 64'(e.seg_t3));
    if (step_o) step_cnt++;
    if (wrap_o) wrap_cnt++;
    $display("[TB] cyc %0d rst=%0b en=%0b dir_i=%0b mode=%0b per=%0d -> step=%0b wrap=%0b pos=%0d dir=%0b seg=%012h",
             cyc, r, en, d, mode_v, per, step_o, wrap_o, pos_o, dir_o, seg7_o);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; dir_i = 1'b0; mode_i = 1'b0; period_i = '0;

    // Reset, with en_i high on the second edge
    drive(1, 0, 0, 0, 3);
    drive(1, 1, 0, 0, 3);
    check_val("rst_pos", 64'(pos_o), 64'd0);
    check_val("rst_disp0", 64'(seg7_o[7:0]), 64'h01);
    check_val("rst_others", 64'(seg7_o[47:8]), 64'd0);

    // LOOP clockwise, period 3: one step every 4 cycles
    step_cnt = 0; wrap_cnt = 0;
    repeat (28) drive(0, 1, 0, 0, 3);
    check_val("loop_steps7", 64'(step_cnt), 64'd7);
    check_val("loop_pos7", 64'(pos_o), 64'd7);
    check_val("pos7_disp5", 64'(seg7_o[47:40]), 64'h04);
    repeat (36) drive(0, 1, 0, 0, 3);
    check_val("loop_steps16", 64'(step_cnt), 64'd16);
    check_val("loop_wraps", 64'(wrap_cnt), 64'd1);
    check_val("loop_pos_wrapped", 64'(pos_o), 64'd0);
    check_val("loop_wrap_pulse", 64'(wrap_o), 64'd1);

    // Hold with en_i low keeps the partial tick count
    step_cnt = 0;
    repeat (2) drive(0, 1, 0, 0, 3);
    repeat (10) drive(0, 0, 0, 0, 3);
    check_val("hold_no_step", 64'(step_cnt), 64'd0);
    drive(0, 1, 0, 0, 3);
    check_val("resume_not_yet", 64'(step_cnt), 64'd0);
    drive(0, 1, 0, 0, 3);
    check_val("resume_step", 64'(step_cnt), 64'd1);
    check_val("resume_pos", 64'(pos_o), 64'd1);

    // LOOP counter-clockwise through 0 -> 15
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    check_val("ccw_pos15", 64'(pos_o), 64'd15);
    check_val("ccw_wrap", 64'(wrap_o), 64'd1);
    check_val("ccw_disp0_f", 64'(seg7_o[7:0]), 64'h20);

    // Walk to pos 14 clockwise, then BOUNCE (dir_i high must be ignored)
    repeat (15) drive(0, 1, 0, 0, 0);
    check_val("pre_bounce_pos", 64'(pos_o), 64'd14);
    drive(0, 1, 1, 1, 0);
    check_val("bounce_pos15", 64'(pos_o), 64'd15);
    drive(0, 1, 1, 1, 0);
    check_val("bounce_rev_pos", 64'(pos_o), 64'd14);
    check_val("bounce_rev_wrap", 64'(wrap_o), 64'd1);
    check_val("bounce_rev_dir", 64'(dir_o), 64'd1);
    repeat (14) drive(0, 1, 0, 1, 0);
    check_val("bounce_pos0", 64'(pos_o), 64'd0);
    drive(0, 1, 1, 1, 0);
    check_val("bounce_back_pos", 64'(pos_o), 64'd1);
    check_val("bounce_back_wrap", 64'(wrap_o), 64'd1);
    check_val("bounce_back_dir", 64'(dir_o), 64'd0);

    // TAIL=3 at pos 1 heading clockwise
    check_val("tail3_disp0", 64'(seg3[7:0]), 64'h21);
    check_val("tail3_disp1", 64'(seg3[15:8]), 64'h01);

    // Reset at pos 9 with en_i high
    repeat (8) drive(0, 1, 0, 0, 0);
    check_val("pre_rst_pos9", 64'(pos_o), 64'd9);
    drive(1, 1, 0, 0, 3);
    check_val("midrst_pos", 64'(pos_o), 64'd0);
    check_val("midrst_step", 64'(step_o), 64'd0);
    check_val("midrst_disp0", 64'(seg7_o[7:0]), 64'h01);

    // First step period_i+1 enabled cycles after release
    step_cnt = 0;
    repeat (3) drive(0, 1, 0, 0, 3);
    check_val("post_rst_wait", 64'(step_cnt), 64'd0);
    drive(0, 1, 0, 0, 3);
    check_val("post_rst_step", 64'(step_o), 64'd1);

    // Lowering period below the running tick steps on the next edge
    repeat (5) drive(0, 1, 0, 0, 10);
    drive(0, 1, 0, 0, 2);
    check_val("period_drop_step", 64'(step_o), 64'd1);

    // BOUNCE entered at pos 0 while heading outward
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    check_val("entry_pos0", 64'(pos_o), 64'd0);
    drive(0, 1, 1, 1, 0);
    check_val("entry_rev_pos", 64'(pos_o), 64'd1);
    check_val("entry_rev_wrap", 64'(wrap_o), 64'd1);

    // Random traffic against the model
    repeat (300) begin
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
